// File: rtl/led_panel_capture.sv
// led_panel_capture
// Passive capture of a two-half serial LED panel bus. Shift-clock edges push
// the RGB lines into upper (rising) and lower (falling) 32-bit shift
// registers. A latch rising edge copies both halves into a 4-row frame store
// at the current row address. The stored pixels can be read back one pixel
// per cycle through a registered port.
// A sticky flag records any latch whose shift count differs from EXP_SHIFTS.

module led_panel_capture #(
  parameter int EXP_SHIFTS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_in,
  input  logic       latch_in,
  input  logic       blank_in,
  input  logic       aclk_in,
  input  logic       arst_in,
  input  logic       red_in,
  input  logic       green_in,
  input  logic       blue_in,
  input  logic [1:0] rd_row,
  input  logic       rd_half,
  input  logic [4:0] rd_col,
  output logic [2:0] rd_rgb,
  output logic [1:0] row_out,
  output logic       lit,
  output logic       frame_done,
  output logic       err_count
);

  localparam logic [5:0] EXP_CNT = 6'(EXP_SHIFTS);
  localparam logic [5:0] CNT_MAX = 6'd63;

  // previous-cycle copies of the panel control lines
  logic sclk_q;
  logic latch_q;
  logic aclk_q;

  logic sclk_rise;
  logic sclk_fall;
  logic latch_rise;
  logic aclk_rise;

  // channel index 2 = red, 1 = green, 0 = blue
  logic [2:0]       pix;
  logic [2:0][31:0] up_q;
  logic [2:0][31:0] up_d;
  logic [2:0][31:0] lo_q;
  logic [2:0][31:0] lo_d;

  logic [5:0] rise_cnt_q;
  logic [5:0] rise_cnt_d;
  logic [5:0] cnt_inc;

  logic err_q;
  logic err_d;

  logic [1:0] row_q;
  logic [1:0] row_d;

  logic frame_done_q;
  logic frame_done_d;

  logic lit_q;

  logic [2:0] rd_addr;
  logic [2:0] rd_rgb_q;
  logic [2:0] rd_rgb_d;

  // frame store entry = {row, half}; half 0 = upper, 1 = lower
  logic [2:0][31:0] mem_q [8];

  assign pix        = {red_in, green_in, blue_in};
  assign sclk_rise  =  sclk_in  & ~sclk_q;
  assign sclk_fall  = ~sclk_in  &  sclk_q;
  assign latch_rise =  latch_in & ~latch_q;
  assign aclk_rise  =  aclk_in  & ~aclk_q;

  // next shift-register contents; the newest bit enters at column 0
  always_comb begin
    up_d = up_q;
    lo_d = lo_q;
    for (int ch = 0; ch < 3; ch++) begin
      if (sclk_rise) up_d[ch] = {up_q[ch][30:0], pix[ch]};
      if (sclk_fall) lo_d[ch] = {lo_q[ch][30:0], pix[ch]};
    end
  end

  // saturating rise counter; the latch compare sees an edge from the same cycle
  always_comb begin
    cnt_inc = rise_cnt_q;
    if (sclk_rise && (rise_cnt_q != CNT_MAX)) cnt_inc = rise_cnt_q + 6'd1;
    rise_cnt_d = latch_rise ? 6'd0 : cnt_inc;
    err_d      = err_q | (latch_rise & (cnt_inc != EXP_CNT));
  end

  // row address: level reset wins over the address clock
  always_comb begin
    row_d = row_q;
    if (arst_in)        row_d = 2'd0;
    else if (aclk_rise) row_d = row_q + 2'd1;
    frame_done_d = latch_rise & (row_q == 2'd3);
  end

  // readback mux from the registered store, so a same-cycle write reads old data
  always_comb begin
    rd_addr  = {rd_row, rd_half};
    rd_rgb_d = {mem_q[rd_addr][2][rd_col],
                mem_q[rd_addr][1][rd_col],
                mem_q[rd_addr][0][rd_col]};
  end

  // edge-detect history; reset values match the bus idle levels
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q  <= 1'b1;
      latch_q <= 1'b0;
      aclk_q  <= 1'b0;
    end else begin
      sclk_q  <= sclk_in;
      latch_q <= latch_in;
      aclk_q  <= aclk_in;
    end
  end

  // shift registers, counter, error flag, row address and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      up_q         <= '0;
      lo_q         <= '0;
      rise_cnt_q   <= '0;
      err_q        <= 1'b0;
      row_q        <= 2'd0;
      frame_done_q <= 1'b0;
      lit_q        <= 1'b0;
      rd_rgb_q     <= 3'd0;
    end else begin
      up_q         <= up_d;
      lo_q         <= lo_d;
      rise_cnt_q   <= rise_cnt_d;
      err_q        <= err_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
      lit_q        <= ~blank_in;
      rd_rgb_q     <= rd_rgb_d;
    end
  end

  // frame store: latch copies the post-shift halves into the pre-change row
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem_q[i] <= '0;
    end else if (latch_rise) begin
      mem_q[{row_q, 1'b0}] <= up_d;
      mem_q[{row_q, 1'b1}] <= lo_d;
    end
  end

  assign rd_rgb     = rd_rgb_q;
  assign row_out    = row_q;
  assign lit        = lit_q;
  assign frame_done = frame_done_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_led_panel_capture.sv
// Directed bench for led_panel_capture: table-driven frame readback plus
// hand-written sequences for latch/shift coincidence, row wrap and reset.

module tb_led_panel_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk_in, latch_in, blank_in, aclk_in, arst_in;
  logic       red_in, green_in, blue_in;
  logic [1:0] rd_row;
  logic       rd_half;
  logic [4:0] rd_col;
  logic [2:0] rd_rgb;
  logic [1:0] row_out;
  logic       lit, frame_done, err_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] row;
    logic       half;
    logic [4:0] col;
    logic [2:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [16];

  led_panel_capture #(.EXP_SHIFTS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .sclk_in    (sclk_in),
    .latch_in   (latch_in),
    .blank_in   (blank_in),
    .aclk_in    (aclk_in),
    .arst_in    (arst_in),
    .red_in     (red_in),
    .green_in   (green_in),
    .blue_in    (blue_in),
    .rd_row     (rd_row),
    .rd_half    (rd_half),
    .rd_col     (rd_col),
    .rd_rgb     (rd_rgb),
    .row_out    (row_out),
    .lit        (lit),
    .frame_done (frame_done),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_rgb(input logic [2:0] v);
    {red_in, green_in, blue_in} = v;
  endtask

  // one panel clock pulse: falling edge loads the lower half, rising the upper
  task automatic sclk_pulse(input logic [2:0] fall_rgb, input logic [2:0] rise_rgb);
    sclk_in = 1'b0; set_rgb(fall_rgb); tick();
    sclk_in = 1'b1; set_rgb(rise_rgb); tick();
  endtask

  function automatic logic [2:0] up_pat(input int r, input int c);
    logic [4:0] cb;
    cb = 5'(c);
    case (r)
      0:       return {cb[0], cb[0], cb[0]};
      1:       return {1'b1, 1'b0, cb[1]};
      2:       return {cb[4], 2'b00};
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [2:0] lo_pat(input int r, input int c);
    logic [4:0] cb;
    cb = 5'(c);
    case (r)
      0:       return 3'b111;
      1:       return {1'b0, 1'b1, cb[2]};
      2:       return 3'b101;
      default: return {cb[3], cb[3], 1'b0};
    endcase
  endfunction

  // n pulses whose k-th bit is destined for column 31-k
  task automatic write_row(input int r, input int n);
    for (int k = 0; k < n; k++) sclk_pulse(lo_pat(r, 31 - k), up_pat(r, 31 - k));
  endtask

  task automatic latch_pulse(input logic exp_fd);
    latch_in = 1'b1; tick();
    check("frame_done_after_latch", frame_done, exp_fd);
    latch_in = 1'b0; tick();
    check("frame_done_cleared", frame_done, 0);
  endtask

  task automatic aclk_pulse(input logic [1:0] exp_row);
    aclk_in = 1'b1; tick();
    check("row_out_after_aclk", row_out, exp_row);
    aclk_in = 1'b0; tick();
  endtask

  task automatic rd_check(input string name, input logic [1:0] r, input logic h,
                          input logic [4:0] c, input logic [2:0] exp);
    rd_row = r; rd_half = h; rd_col = c;
    tick();
    check(name, rd_rgb, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1; sclk_in = 1'b1; latch_in = 1'b0; aclk_in = 1'b0; arst_in = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0]  = '{2'd0, 1'b0, 5'd0,  3'b000};
    vecs[1]  = '{2'd0, 1'b0, 5'd1,  3'b111};
    vecs[2]  = '{2'd0, 1'b0, 5'd31, 3'b111};
    vecs[3]  = '{2'd0, 1'b0, 5'd30, 3'b000};
    vecs[4]  = '{2'd0, 1'b1, 5'd5,  3'b111};
    vecs[5]  = '{2'd0, 1'b1, 5'd0,  3'b111};
    vecs[6]  = '{2'd1, 1'b0, 5'd2,  3'b101};
    vecs[7]  = '{2'd1, 1'b0, 5'd1,  3'b100};
    vecs[8]  = '{2'd1, 1'b1, 5'd4,  3'b011};
    vecs[9]  = '{2'd1, 1'b1, 5'd3,  3'b010};
    vecs[10] = '{2'd2, 1'b0, 5'd16, 3'b100};
    vecs[11] = '{2'd2, 1'b0, 5'd15, 3'b000};
    vecs[12] = '{2'd2, 1'b1, 5'd9,  3'b101};
    vecs[13] = '{2'd3, 1'b0, 5'd7,  3'b010};
    vecs[14] = '{2'd3, 1'b1, 5'd8,  3'b110};
    vecs[15] = '{2'd3, 1'b1, 5'd7,  3'b000};

    reset = 1'b1; sclk_in = 1'b1; latch_in = 1'b0; blank_in = 1'b1;
    aclk_in = 1'b0; arst_in = 1'b0; set_rgb(3'b000);
    rd_row = 2'd0; rd_half = 1'b0; rd_col = 5'd0;
    tick(); tick(); tick();
    check("reset_row_out", row_out, 0);
    check("reset_lit", lit, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_err_count", err_count, 0);
    check("reset_rd_rgb", rd_rgb, 0);
    reset = 1'b0;
    tick();
    check("lit_blanked", lit, 0);
    blank_in = 1'b0; tick();
    check("lit_on", lit, 1);
    blank_in = 1'b1; tick();
    check("lit_off", lit, 0);

    // four full rows, each followed by an address clock
    for (int r = 0; r < 4; r++) begin
      write_row(r, 32);
      latch_pulse(r == 3);
      check("err_after_good_row", err_count, 0);
      aclk_pulse(2'((r + 1) % 4));
    end

    for (int i = 0; i < 16; i++)
      rd_check($sformatf("rd_vec%0d", i), vecs[i].row, vecs[i].half, vecs[i].col, vecs[i].exp);

    // address reset and address clock rising together
    aclk_pulse(2'd1);
    aclk_pulse(2'd2);
    arst_in = 1'b1; aclk_in = 1'b1; tick();
    check("arst_priority", row_out, 0);
    arst_in = 1'b0; aclk_in = 1'b0; tick();
    check("arst_hold", row_out, 0);

    // final rise coincides with latch; reading the entry under write gives old data
    rd_row = 2'd0; rd_half = 1'b0; rd_col = 5'd1;
    for (int k = 0; k < 31; k++) sclk_pulse(3'b010, 3'b000);
    sclk_in = 1'b0; set_rgb(3'b010); tick();
    sclk_in = 1'b1; set_rgb(3'b101); latch_in = 1'b1; tick();
    check("rd_old_during_write", rd_rgb, 3'b111);
    latch_in = 1'b0; tick();
    check("rd_new_after_write", rd_rgb, 3'b000);
    check("err_coincident_latch", err_count, 0);
    rd_check("coincident_col0_upper", 2'd0, 1'b0, 5'd0, 3'b101);
    rd_check("coincident_col0_lower", 2'd0, 1'b1, 5'd0, 3'b010);
    rd_check("coincident_col31_upper", 2'd0, 1'b0, 5'd31, 3'b000);

    // short row sets the sticky error flag
    write_row(0, 31);
    latch_pulse(1'b0);
    check("err_short_row", err_count, 1);
    write_row(0, 32);
    latch_pulse(1'b0);
    check("err_sticky", err_count, 1);

    // reset mid-row discards the partial shifts
    for (int k = 0; k < 10; k++) sclk_pulse(3'b111, 3'b111);
    do_reset();
    check("post_reset_err", err_count, 0);
    check("post_reset_row", row_out, 0);
    write_row(0, 32);
    latch_pulse(1'b0);
    check("err_after_reset_row", err_count, 0);
    rd_check("rst_row0_up1", 2'd0, 1'b0, 5'd1, 3'b111);
    rd_check("rst_row0_up2", 2'd0, 1'b0, 5'd2, 3'b000);
    rd_check("rst_row0_lo9", 2'd0, 1'b1, 5'd9, 3'b111);
    rd_check("rst_row1_clear", 2'd1, 1'b0, 5'd2, 3'b000);
    rd_check("rst_row2_clear", 2'd2, 1'b1, 5'd9, 3'b000);
    rd_check("rst_row3_clear", 2'd3, 1'b0, 5'd7, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_panel_capture.md
LED_PANEL_CAPTURE -- requirements
Module: led_panel_capture

Interface
REQ-001 SHALL have parameter EXP_SHIFTS, default 32, meaning the sclk rising edges expected between consecutive latch pulses.
REQ-002 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port sclk_in  in  1  panel shift clock, idles high.
REQ-005 SHALL have port latch_in  in  1  panel latch, active-high.
REQ-006 SHALL have port blank_in  in  1  panel blank, 1 = LEDs off.
REQ-007 SHALL have port aclk_in  in  1  row-address clock.
REQ-008 SHALL have port arst_in  in  1  row-address reset, active-high.
REQ-009 SHALL have ports red_in, green_in, blue_in  in  1 each  serial pixel data.
REQ-010 SHALL have ports rd_row  in  2, rd_half  in  1 (0 = upper, 1 = lower), rd_col  in  5  readback address.
REQ-011 SHALL have port rd_rgb  out  3  readback pixel {r,g,b}.
REQ-012 SHALL have port row_out  out  2  current decoded row address.
REQ-013 SHALL have port lit  out  1  registered ~blank_in.
REQ-014 SHALL have port frame_done  out  1  one-cycle pulse when row 3 is latched.
REQ-015 SHALL have port err_count  out  1  sticky shift-count error flag.

Function
REQ-016 SHALL sample all inputs on clk and detect edges by comparing each input with its value from the previous cycle.
REQ-017 sclk rise SHALL shift {r,g,b} into the upper shift registers: sh <= {sh[30:0], bit}.
REQ-018 sclk fall SHALL shift {r,g,b} into the lower shift registers in the same way.
REQ-019 Data SHALL be taken from red/green/blue_in sampled in the same clk cycle the sclk edge is detected.
REQ-020 After 32 shifts, the first bit shifted SHALL sit at column 31 and the last at column 0.
REQ-021 rise_cnt (6 bit) SHALL increment on each sclk rise, saturate at 63, and clear on latch.
REQ-022 latch_in rise SHALL copy both halves (6 x 32 bits) into frame memory row row_out.
REQ-023 On a latch_in rise, rise_cnt != EXP_SHIFTS SHALL set err_count.
REQ-024 err_count SHALL be cleared only by reset.
REQ-025 An sclk edge in the same cycle as a latch rise SHALL be shifted first; the transferred data SHALL include that bit and rise_cnt SHALL include that edge.
REQ-026 arst_in high (level) SHALL force row_out to 0, with priority over aclk_in.
REQ-027 An aclk_in rise with arst_in low SHALL increment row_out modulo 4 (3 wraps to 0).
REQ-028 A latch rise coinciding with a row change SHALL write to the pre-change row.
REQ-029 frame_done SHALL pulse high the cycle after the frame-memory write of row 3, for exactly 1 cycle.
REQ-030 rd_rgb SHALL be registered with 1-cycle latency from rd_row/rd_half/rd_col.
REQ-031 A read of the entry being written in the same cycle SHALL return the old data.
REQ-032 lit SHALL equal ~blank_in delayed by 1 cycle.
REQ-033 The shift registers SHALL be unaffected by latch; they keep shifting and are overwritten by later shifts.

Reset
REQ-034 During reset SHALL set row_out=0, rise_cnt=0, err_count=0, frame_done=0, lit=0, rd_rgb=0, all shift registers and frame memory to 0.
REQ-035 During reset SHALL set previous-value registers sclk=1, latch=0, aclk=0.
REQ-036 Reset asserted mid-row SHALL discard partial shifts, and the first latch after reset SHALL write row 0.
REQ-037 The first cycle after reset SHALL NOT detect any edge from the idle levels sclk=1, latch=0, aclk=0.

Verification
REQ-038 32 sclk pulses: upper bits = col index bit0 on rises, lower all 1, then latch, row 0 -> rd(0,0,c) = {c[0],c[0],c[0]}, rd(0,1,c) = 3'b111, err_count=0.
REQ-039 31 sclk rises then latch -> err_count=1; it stays 1 through further correct rows until reset.
REQ-040 Four rows, each latch followed by an aclk pulse -> row_out 0,1,2,3,0; frame_done pulses once, after the row-3 latch.
REQ-041 arst_in and aclk_in rise together with row_out=2 -> row_out=0 the next cycle.
REQ-042 Final sclk rise in the same cycle as the latch rise -> column 0 holds that final bit, err_count=0.
REQ-043 Reset asserted after 10 shifts, then a full correct row -> row 0 data correct, other rows read 0, err_count=0.
